fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select and IF/ID pipeline register with a RUN/HOLD stall FSM.
// Define FETCH_PERF_CNT_EN to build the saturating stall/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        awrite,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  state_e      state_q;
  logic [31:0] pc_q, pc_d, pc4;
  logic [31:0] ifid_pc4_q, ifid_inst_q;
  logic        ifid_valid_q;
  logic [31:0] sel;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    sel = pc4;
    case (pc_src)
      2'b00: sel = pc4;
      2'b01: sel = br_target;
      2'b10: sel = j_target;
      2'b11: sel = jr_target;
      default: sel = pc4;
    endcase
    pc_d = {sel[31:2], 2'b00};
  end

  // PCwrite=0 wins over flush: pc holds and the redirect is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC_A;
      ifid_pc4_q   <= '0;
      ifid_inst_q  <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (!PCwrite) state_q <= HOLD;
        HOLD:    if (PCwrite)  state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (PCwrite) pc_q <= pc_d;
      if (awrite) begin
        if (flush) begin
          ifid_pc4_q   <= '0;
          ifid_inst_q  <= '0;
          ifid_valid_q <= 1'b0;
        end else begin
          ifid_pc4_q   <= pc4;
          ifid_inst_q  <= inst_in;
          ifid_valid_q <= 1'b1;
        end
      end
    end
  end

  assign pc          = pc_q;
  assign IF_ID_pc4   = ifid_pc4_q;
  assign IF_ID_inst  = ifid_inst_q;
  assign IF_ID_valid = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCwrite && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (PCwrite && awrite && flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a cycle model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst, PCwrite, awrite, flush;
  logic [1:0]  pc_src;
  logic [31:0] br_target, j_target, jr_target, inst_in;
  logic [31:0] pc, IF_ID_pc4, IF_ID_inst;
  logic        IF_ID_valid;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc, m_pc4, m_inst;
  logic        m_valid;
  logic [15:0] m_stall, m_flush;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .PCwrite(PCwrite), .awrite(awrite), .flush(flush),
    .pc_src(pc_src), .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
    .inst_in(inst_in), .pc(pc), .IF_ID_pc4(IF_ID_pc4), .IF_ID_inst(IF_ID_inst),
    .IF_ID_valid(IF_ID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RST_PC & ~32'h3; m_pc4 = '0; m_inst = '0; m_valid = 1'b0;
    m_stall = '0; m_flush = '0;
  endtask

  // Advance the model by one edge using the current inputs, then let the DUT take the same edge.
  task automatic step();
    logic [31:0] tgt;
    case (pc_src)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = br_target;
      2'd2: tgt = j_target;
      default: tgt = jr_target;
    endcase
    if (awrite) begin
      m_pc4   = flush ? 32'd0 : m_pc + 32'd4;
      m_inst  = flush ? 32'd0 : inst_in;
      m_valid = !flush;
    end
`ifdef FETCH_PERF_CNT_EN
    if (!PCwrite && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (PCwrite && awrite && flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
`endif
    if (PCwrite) m_pc = tgt & ~32'h3;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic aw, input logic fl, input logic [1:0] src,
                       input logic [31:0] br, input logic [31:0] j, input logic [31:0] jr,
                       input logic [31:0] inst);
    PCwrite = pw; awrite = aw; flush = fl; pc_src = src;
    br_target = br; j_target = j; jr_target = jr; inst_in = inst;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    model_reset();
    #2;
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, m_pc); end
    checks++; if (IF_ID_valid !== 1'b0 || IF_ID_inst !== 32'h0 || IF_ID_pc4 !== 32'h0) begin
      errors++; $display("FAIL reset_ifid got=%h/%h/%b exp=0/0/0", IF_ID_pc4, IF_ID_inst, IF_ID_valid); end
    checks++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
    @(posedge clk); #1;
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL reset_held_pc got=%h exp=%h", pc, m_pc); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_first_fetch();
    drive(1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h2008_0005);
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL first_pc got=%h exp=%h", pc, 32'h4); end
    checks++; if (IF_ID_pc4 !== 32'h4) begin errors++; $display("FAIL first_pc4 got=%h exp=%h", IF_ID_pc4, 32'h4); end
    checks++; if (IF_ID_inst !== 32'h2008_0005) begin errors++; $display("FAIL first_inst got=%h exp=%h", IF_ID_inst, 32'h2008_0005); end
    checks++; if (IF_ID_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", IF_ID_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] pc4_s, inst_s;
    drive(1, 1, 0, 2'd1, 32'h10, 32'h0, 32'h0, 32'h1111_2222);
    step();
    pc4_s = m_pc4; inst_s = m_inst;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 2'd1, 32'h80, 32'h0, 32'h0, $urandom);
      step();
    end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc got=%h exp=%h", pc, 32'h10); end
    checks++; if (IF_ID_pc4 !== pc4_s || IF_ID_inst !== inst_s || IF_ID_valid !== 1'b1) begin
      errors++; $display("FAIL stall_ifid got=%h/%h/%b exp=%h/%h/1", IF_ID_pc4, IF_ID_inst, IF_ID_valid, pc4_s, inst_s); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
`else
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt got=%0d exp=0", stall_cnt); end
`endif
  endtask

  task automatic test_flush();
    drive(1, 1, 0, 2'd2, 32'h0, 32'h20, 32'h0, 32'h3333_4444);
    step();
    drive(1, 1, 1, 2'd1, 32'h0000_0043, 32'h0, 32'h0, 32'h5555_6666);
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL flush_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (IF_ID_inst !== 32'h0 || IF_ID_valid !== 1'b0 || IF_ID_pc4 !== 32'h0) begin
      errors++; $display("FAIL flush_ifid got=%h/%h/%b exp=0/0/0", IF_ID_pc4, IF_ID_inst, IF_ID_valid); end
    checks++; if (flush_cnt !== m_flush) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, m_flush); end
  endtask

  task automatic test_stall_priority();
    logic [31:0] pc_s;
    logic [15:0] fc_s;
    drive(1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h7777_8888);
    step();
    pc_s = m_pc; fc_s = m_flush;
    drive(0, 0, 1, 2'd2, 32'h0, 32'h100, 32'h0, 32'h9999_AAAA);
    step();
    checks++; if (pc !== pc_s) begin errors++; $display("FAIL prio_pc got=%h exp=%h", pc, pc_s); end
    checks++; if (IF_ID_inst !== 32'h7777_8888 || IF_ID_valid !== 1'b1) begin
      errors++; $display("FAIL prio_ifid got=%h/%b exp=%h/1", IF_ID_inst, IF_ID_valid, 32'h7777_8888); end
    checks++; if (flush_cnt !== fc_s) begin errors++; $display("FAIL prio_flush_cnt got=%0d exp=%0d", flush_cnt, fc_s); end
  endtask

  task automatic test_wrap();
    drive(1, 1, 0, 2'd3, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0);
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    drive(1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0123_4567);
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++; if (IF_ID_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=0", IF_ID_pc4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      step();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end
      checks++; if (IF_ID_pc4 !== m_pc4 || IF_ID_inst !== m_inst || IF_ID_valid !== m_valid) begin
        errors++; $display("FAIL rand_ifid cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i,
                           IF_ID_pc4, IF_ID_inst, IF_ID_valid, m_pc4, m_inst, m_valid); end
      checks++; if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        errors++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
    end
  endtask

  task automatic test_reset_in_stall();
    drive(0, 0, 1, 2'd1, 32'h0000_0200, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 65540; i++) step();
    checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL sat_stall got=%h exp=%h", stall_cnt, m_stall); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL async_rst_pc got=%h exp=%h", pc, m_pc); end
    checks++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
      errors++; $display("FAIL async_rst_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
    checks++; if (IF_ID_valid !== 1'b0 || IF_ID_inst !== 32'h0) begin
      errors++; $display("FAIL async_rst_ifid got=%h/%b exp=0/0", IF_ID_inst, IF_ID_valid); end
    #1;
    rst = 1'b1;
    drive(1, 1, 0, 2'd0, 32'h0000_0200, 32'h0, 32'h0, 32'hCAFE_0001);
    step();
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL resume_pc got=%h exp=%h", pc, m_pc); end
    checks++; if (IF_ID_inst !== 32'hCAFE_0001 || IF_ID_valid !== 1'b1) begin
      errors++; $display("FAIL resume_ifid got=%h/%b exp=%h/1", IF_ID_inst, IF_ID_valid, 32'hCAFE_0001); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_flush();
    test_stall_priority();
    test_wrap();
    test_random();
    test_reset_in_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
